// File: rtl/image_write_stream_if.sv
// Byte-wide valid/ready stream carrying the BMP file out of image_write_stream.
interface image_write_stream_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_sof;
  logic       o_eof;

  modport master (output o_data, output o_valid, output o_sof, output o_eof, input i_ready);
  modport slave  (input o_data, input o_valid, input o_sof, input o_eof, output i_ready);
endinterface

// File: rtl/image_write_stream.sv
// Captures one RGB888 frame (two pixels per beat) into a buffer, then streams it
// out as a 24-bit BMP file: 54-byte header followed by bottom-up B,G,R pixel data.
module image_write_stream #(
  parameter int unsigned WIDTH         = 768,
  parameter int unsigned HEIGHT        = 512,
  parameter int unsigned BMP_HDR_BYTES = 54
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSYNC,
  input  logic [7:0]                  DATA_R0,
  input  logic [7:0]                  DATA_G0,
  input  logic [7:0]                  DATA_B0,
  input  logic [7:0]                  DATA_R1,
  input  logic [7:0]                  DATA_G1,
  input  logic [7:0]                  DATA_B1,
  image_write_stream_if.master        bs,
  output logic                        write_done,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int unsigned NBEAT   = WIDTH * HEIGHT / 2;
  localparam int unsigned NPIX    = WIDTH * HEIGHT * 3;
  localparam int unsigned FSIZE   = NPIX + BMP_HDR_BYTES;
  localparam int unsigned ADDR_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned RA_W    = $clog2(NBEAT + 1);
  localparam int unsigned COL_W   = $clog2(WIDTH);
  localparam int unsigned IDX_W   = $clog2(FSIZE);
  localparam int unsigned WORD_W  = 48;
  localparam int unsigned WR_INIT = (HEIGHT - 1) * (WIDTH / 2);

  typedef enum logic [1:0] {ST_CAPTURE, ST_HEADER, ST_PIXEL} state_t;

  state_t              r_state, w_state_nxt;
  logic [COL_W-1:0]    r_col, w_col_nxt;
  logic [ADDR_W-1:0]   r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [2:0]          r_lane, w_lane_nxt;
  logic [WORD_W-1:0]   r_cur, w_cur_nxt;
  logic                r_cur_vld, w_cur_vld_nxt;
  logic                r_q_vld, w_q_vld_nxt;
  logic [RA_W-1:0]     r_rd_addr, w_rd_addr_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_sof, w_sof_nxt;
  logic                r_eof, w_eof_nxt;
  logic                r_write_done, w_write_done_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic                r_overflow, w_overflow_nxt;

  logic [WORD_W-1:0]   r_mem [NBEAT];
  logic [WORD_W-1:0]   r_q;
  logic                w_mem_we;
  logic                w_rd_en;
  logic                w_acc;
  logic [IDX_W-1:0]    w_idx_inc;
  logic                w_pix_load;
  logic                w_last_lane;
  logic                w_consume;
  logic [WORD_W-1:0]   w_wr_word;

  assign w_acc     = r_valid & bs.i_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_wr_word = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};

  // Little-endian BMP/DIB header byte lookup
  function automatic logic [7:0] hdr_byte(input logic [5:0] i);
    logic [31:0] v;
    logic [5:0]  b;
    v = '0;
    b = i;
    if (i == 6'd0)                    v = 32'h42;
    else if (i == 6'd1)               v = 32'h4D;
    else if (i >= 6'd2  && i <= 6'd5)  begin v = 32'(FSIZE);         b = 6'd2;  end
    else if (i >= 6'd10 && i <= 6'd13) begin v = 32'(BMP_HDR_BYTES); b = 6'd10; end
    else if (i >= 6'd14 && i <= 6'd17) begin v = 32'd40;             b = 6'd14; end
    else if (i >= 6'd18 && i <= 6'd21) begin v = 32'(WIDTH);         b = 6'd18; end
    else if (i >= 6'd22 && i <= 6'd25) begin v = 32'(HEIGHT);        b = 6'd22; end
    else if (i >= 6'd26 && i <= 6'd27) begin v = 32'd1;              b = 6'd26; end
    else if (i >= 6'd28 && i <= 6'd29) begin v = 32'd24;             b = 6'd28; end
    return 8'(v >> {i - b, 3'b000});
  endfunction

  // Frame buffer: write during capture, 1-cycle registered read for prefetch
  always_ff @(posedge HCLK) begin
    if (w_mem_we) r_mem[r_wr_addr] <= w_wr_word;
    if (w_rd_en)  r_q <= r_mem[ADDR_W'(r_rd_addr)];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_CAPTURE;
      r_col        <= '0;
      r_beat       <= '0;
      r_wr_addr    <= ADDR_W'(WR_INIT);
      r_idx        <= '0;
      r_lane       <= '0;
      r_cur        <= '0;
      r_cur_vld    <= 1'b0;
      r_q_vld      <= 1'b0;
      r_rd_addr    <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_write_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_beat       <= w_beat_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_idx        <= w_idx_nxt;
      r_lane       <= w_lane_nxt;
      r_cur        <= w_cur_nxt;
      r_cur_vld    <= w_cur_vld_nxt;
      r_q_vld      <= w_q_vld_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_sof        <= w_sof_nxt;
      r_eof        <= w_eof_nxt;
      r_write_done <= w_write_done_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_beat_nxt       = r_beat;
    w_wr_addr_nxt    = r_wr_addr;
    w_idx_nxt        = r_idx;
    w_lane_nxt       = r_lane;
    w_cur_nxt        = r_cur;
    w_cur_vld_nxt    = r_cur_vld;
    w_q_vld_nxt      = r_q_vld;
    w_rd_addr_nxt    = r_rd_addr;
    w_data_nxt       = r_data;
    w_valid_nxt      = r_valid;
    w_sof_nxt        = r_sof;
    w_eof_nxt        = r_eof;
    w_write_done_nxt = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_overflow_nxt   = r_overflow | (HSYNC & (r_state != ST_CAPTURE));
    w_mem_we         = 1'b0;
    w_rd_en          = 1'b0;
    w_pix_load       = 1'b0;
    w_last_lane      = 1'b0;
    w_consume        = 1'b0;

    case (r_state)
      ST_CAPTURE: begin
        if (HSYNC) begin
          w_mem_we = 1'b1;
          if (r_beat == ADDR_W'(NBEAT - 1)) begin
            w_write_done_nxt = 1'b1;
            w_state_nxt      = ST_HEADER;
            w_col_nxt        = '0;
            w_beat_nxt       = '0;
            w_wr_addr_nxt    = ADDR_W'(WR_INIT);
            w_idx_nxt        = '0;
            w_data_nxt       = hdr_byte(6'd0);
            w_valid_nxt      = 1'b1;
            w_sof_nxt        = 1'b1;
            w_eof_nxt        = 1'b0;
          end else begin
            w_beat_nxt = r_beat + ADDR_W'(1);
            // Row wrap jumps from the end of this row to the start of the row above it in the buffer
            if (r_col == COL_W'(WIDTH - 2)) begin
              w_col_nxt     = '0;
              w_wr_addr_nxt = r_wr_addr - ADDR_W'(WIDTH - 1);
            end else begin
              w_col_nxt     = r_col + COL_W'(2);
              w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
            end
          end
        end
      end

      ST_HEADER, ST_PIXEL: begin
        // Two-word prefetch (r_cur, r_q) keeps pixel bytes bubble-free
        w_pix_load  = w_acc && (r_idx != IDX_W'(FSIZE - 1)) && (w_idx_inc >= IDX_W'(BMP_HDR_BYTES));
        w_last_lane = w_pix_load && (r_lane == 3'd5);
        w_consume   = r_q_vld && (!r_cur_vld || w_last_lane);
        if (w_consume) begin
          w_cur_nxt     = r_q;
          w_cur_vld_nxt = 1'b1;
        end else if (w_last_lane) begin
          w_cur_vld_nxt = 1'b0;
        end
        if (w_pix_load) w_lane_nxt = (r_lane == 3'd5) ? 3'd0 : r_lane + 3'd1;
        if ((r_rd_addr < RA_W'(NBEAT)) && (!r_q_vld || w_consume)) begin
          w_rd_en       = 1'b1;
          w_rd_addr_nxt = r_rd_addr + RA_W'(1);
          w_q_vld_nxt   = 1'b1;
        end else if (w_consume) begin
          w_q_vld_nxt   = 1'b0;
        end

        if (w_acc) begin
          if (r_idx == IDX_W'(FSIZE - 1)) begin
            w_valid_nxt      = 1'b0;
            w_data_nxt       = '0;
            w_sof_nxt        = 1'b0;
            w_eof_nxt        = 1'b0;
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = ST_CAPTURE;
            w_idx_nxt        = '0;
            w_lane_nxt       = '0;
            w_rd_addr_nxt    = '0;
            w_cur_vld_nxt    = 1'b0;
            w_q_vld_nxt      = 1'b0;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_sof_nxt = 1'b0;
            w_eof_nxt = (w_idx_inc == IDX_W'(FSIZE - 1));
            if (w_idx_inc < IDX_W'(BMP_HDR_BYTES)) begin
              w_data_nxt = hdr_byte(6'(w_idx_inc));
            end else begin
              w_data_nxt  = r_cur[{r_lane, 3'b000} +: 8];
              w_state_nxt = ST_PIXEL;
            end
          end
        end
      end

      default: w_state_nxt = ST_CAPTURE;
    endcase
  end

  assign bs.o_data   = r_data;
  assign bs.o_valid  = r_valid;
  assign bs.o_sof    = r_sof;
  assign bs.o_eof    = r_eof;
  assign write_done  = r_write_done;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;

endmodule
